// File: rtl/fsm_boton_pkg.sv
// fsm_boton_pkg: button FSM state encoding, shared with the board debug decode
package fsm_boton_pkg;
  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    ESPERA_ON  = 2'b01,
    PRESIONADO = 2'b10,
    ESPERA_OFF = 2'b11
  } estado_t;
endpackage

// File: rtl/fsm_boton_if.sv
// fsm_boton_if: raw button in, clean level / strobe / debug state out
interface fsm_boton_if;
  logic Btn;
  logic Out;
  logic Pulse;
  logic [1:0] Estado;
  modport master (output Btn, input Out, Pulse, Estado);
  modport slave (input Btn, output Out, Pulse, Estado);
endinterface

// File: rtl/fsm_boton_sincronizador.sv
// sincronizador: 2-flop synchronizer for asynchronous board inputs
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/fsm_boton.sv
// fsm_boton: debounced pushbutton front end driving a clean level and a press strobe
module fsm_boton
  import fsm_boton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16,
  parameter bit TOGGLE = 1'b1
) (
  input logic clk,
  input logic rst,
  fsm_boton_if.slave bus
);
  estado_t estado;
  logic [CNT_W-1:0] cnt;
  logic b_s, cnt_fin, acepta, suelta, out, pulse;
  sincronizador u_sinc (.clk(clk), .rst(rst), .d(bus.Btn), .q(b_s));
  assign cnt_fin = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign acepta = estado == ESPERA_ON && b_s && cnt_fin;
  assign suelta = estado == ESPERA_OFF && !b_s && cnt_fin;
  // counter is held at zero outside the wait states so every wait starts fresh
  always_ff @(posedge clk)
    if (!rst) begin
      estado <= REPOSO;
      cnt <= '0;
    end else
      case (estado)
        REPOSO: begin
          if (b_s) estado <= ESPERA_ON;
          cnt <= '0;
        end
        ESPERA_ON:
          if (!b_s) estado <= REPOSO;
          else if (cnt_fin) estado <= PRESIONADO;
          else cnt <= cnt + 1'b1;
        PRESIONADO: begin
          if (!b_s) estado <= ESPERA_OFF;
          cnt <= '0;
        end
        ESPERA_OFF:
          if (b_s) estado <= PRESIONADO;
          else if (cnt_fin) estado <= REPOSO;
          else cnt <= cnt + 1'b1;
        default: begin
          estado <= REPOSO;
          cnt <= '0;
        end
      endcase
  always_ff @(posedge clk)
    if (!rst) begin
      out <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= acepta;
      out <= TOGGLE ? out ^ acepta : (acepta ? 1'b1 : suelta ? 1'b0 : out);
    end
  assign bus.Out = out;
  assign bus.Pulse = pulse;
  assign bus.Estado = estado;
endmodule

// File: tb/tb_fsm_boton.sv
// tb_fsm_boton: per-cycle vector table through a scoreboard queue, plus latency sequences
module tb_fsm_boton;
  typedef struct {
    logic rst;
    logic btn;
    int n;
    logic out;
    logic pulse;
    logic [1:0] est;
  } vec_t;
  typedef struct {
    logic out;
    logic pulse;
    logic [1:0] est;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  int applied = 0;
  int bad = 0;
  vec_t vs[$];
  exp_t sb[$];
  fsm_boton_if bus ();
  fsm_boton_if bus0 ();
  fsm_boton_if bus1 ();
  assign bus.Btn = btn;
  assign bus0.Btn = btn;
  assign bus1.Btn = btn;
  fsm_boton dut (.clk(clk), .rst(rst), .bus(bus));
  fsm_boton #(.TOGGLE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fsm_boton #(.DEBOUNCE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req);
    applied++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask
  task automatic add(input logic r, input logic b, input int n, input logic o, input logic p, input logic [1:0] e);
    vs.push_back('{r, b, n, o, p, e});
  endtask
  initial begin
    exp_t e;
    int k_main, k_one, n_main, n_one;
    // reset with button held, then release reset with button low
    add(1'b0, 1'b1, 3, 1'b0, 1'b0, 2'b00);
    add(1'b1, 1'b0, 4, 1'b0, 1'b0, 2'b00);
    // clean press held 20 cycles
    add(1'b1, 1'b1, 2, 1'b0, 1'b0, 2'b00);
    add(1'b1, 1'b1, 4, 1'b0, 1'b0, 2'b01);
    add(1'b1, 1'b1, 1, 1'b1, 1'b1, 2'b10);
    add(1'b1, 1'b1, 13, 1'b1, 1'b0, 2'b10);
    // release with a one-cycle high glitch
    add(1'b1, 1'b0, 1, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b1, 1, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 1, 1'b1, 1'b0, 2'b11);
    add(1'b1, 1'b0, 1, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 4, 1'b1, 1'b0, 2'b11);
    add(1'b1, 1'b0, 5, 1'b1, 1'b0, 2'b00);
    // bouncy second press: high 2, low 1, high held
    add(1'b1, 1'b1, 2, 1'b1, 1'b0, 2'b00);
    add(1'b1, 1'b0, 1, 1'b1, 1'b0, 2'b01);
    add(1'b1, 1'b1, 1, 1'b1, 1'b0, 2'b01);
    add(1'b1, 1'b1, 1, 1'b1, 1'b0, 2'b00);
    add(1'b1, 1'b1, 4, 1'b1, 1'b0, 2'b01);
    add(1'b1, 1'b1, 1, 1'b0, 1'b1, 2'b10);
    add(1'b1, 1'b1, 10, 1'b0, 1'b0, 2'b10);
    // clean release
    add(1'b1, 1'b0, 2, 1'b0, 1'b0, 2'b10);
    add(1'b1, 1'b0, 4, 1'b0, 1'b0, 2'b11);
    add(1'b1, 1'b0, 4, 1'b0, 1'b0, 2'b00);
    // press/release so Out is high, then reset in the middle of ESPERA_ON
    add(1'b1, 1'b1, 2, 1'b0, 1'b0, 2'b00);
    add(1'b1, 1'b1, 4, 1'b0, 1'b0, 2'b01);
    add(1'b1, 1'b1, 1, 1'b1, 1'b1, 2'b10);
    add(1'b1, 1'b1, 3, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 4, 1'b1, 1'b0, 2'b11);
    add(1'b1, 1'b0, 3, 1'b1, 1'b0, 2'b00);
    add(1'b1, 1'b1, 2, 1'b1, 1'b0, 2'b00);
    add(1'b1, 1'b1, 2, 1'b1, 1'b0, 2'b01);
    add(1'b0, 1'b1, 2, 1'b0, 1'b0, 2'b00);
    add(1'b1, 1'b0, 4, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < vs.size(); i++)
      for (int k = 0; k < vs[i].n; k++) begin
        rst = vs[i].rst;
        btn = vs[i].btn;
        sb.push_back('{vs[i].out, vs[i].pulse, vs[i].est});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d.%0d out", i, k), int'(bus.Out), int'(e.out));
        chk($sformatf("v%0d.%0d pulse", i, k), int'(bus.Pulse), int'(e.pulse));
        chk($sformatf("v%0d.%0d estado", i, k), int'(bus.Estado), int'(e.est));
        chk($sformatf("v%0d.%0d t0 out", i, k), int'(bus0.Out), int'(e.est[1]));
        chk($sformatf("v%0d.%0d t0 pulse", i, k), int'(bus0.Pulse), int'(e.pulse));
        chk($sformatf("v%0d.%0d t0 estado", i, k), int'(bus0.Estado), int'(e.est));
      end
    // press latency: default waits 2+4 edges, single-cycle debounce waits 2+1
    k_main = -1;
    k_one = -1;
    n_main = 0;
    n_one = 0;
    btn = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.Pulse) begin
        n_main++;
        if (k_main < 0) k_main = k;
      end
      if (bus1.Pulse) begin
        n_one++;
        if (k_one < 0) k_one = k;
      end
    end
    chk("press latency", k_main, 6);
    chk("press latency d1", k_one, 3);
    chk("single strobe", n_main, 1);
    chk("single strobe d1", n_one, 1);
    chk("out after press", int'(bus.Out), 1);
    chk("t0 out held", int'(bus0.Out), 1);
    // release latency
    k_main = -1;
    k_one = -1;
    btn = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.Estado == 2'b00 && k_main < 0) k_main = k;
      if (bus1.Estado == 2'b00 && k_one < 0) k_one = k;
      if (k == 4) chk("d1 espera_off one cycle", int'(bus1.Estado), 0);
    end
    chk("release latency", k_main, 6);
    chk("release latency d1", k_one, 3);
    chk("out after release", int'(bus.Out), 1);
    chk("t0 out after release", int'(bus0.Out), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, bad);
    $finish;
  end
endmodule
